bus_master_lsu: RTL and testbench
=================================

// Module: bus_master_lsu
// PURPOSE
//   Load/store bus master between the CPU MEM stage and the system BUS. Turns one-cycle
//   pipeline load/store requests into BUS transactions on addr/data/ctrl, including the
//   inout data bus. Holds each access long enough for peripherals clocked by dev_clk.
//   Returns load data and a completion pulse, and stalls the pipeline until then.
// PARAMETERS
//   AW        16   address width (matches ADDRBUS)
//   DW        16   data width (matches DATABUS)
//   RAM_WAIT  2    access cycles for main memory (addr[15:8] != 8'hFF); must be >= 1
//   DEV_WAIT  200  access cycles for peripherals (addr[15:8] == 8'hFF); >= 2 dev_clk periods
// PORTS
//   clk        in     1   system clock
//   rst_n      in     1   synchronous reset, active-low
//   req_valid  in     1   MEM stage requests an access; held until rsp_valid
//   req_ready  out    1   high only in IDLE; accept = req_valid & req_ready
//   req_we     in     1   1 = store, 0 = load
//   req_addr   in     AW  word address
//   req_wdata  in     DW  store data
//   rsp_valid  out    1   one-cycle completion pulse (loads and stores)
//   rsp_rdata  out    DW  load data, valid with rsp_valid, held until next load completes
//   stall      out    1   comb: req_valid & ~rsp_valid (freezes upstream pipeline)
//   addr       out    AW  BUS address
//   data       inout  DW  BUS data; driven only while drive_en, else 'z
//   ctrl       out    1   BUS direction: 1 = write, 0 = read
// BEHAVIOUR
//   Reset (rst_n low at posedge):
//     state = IDLE; addr = 0; ctrl = 0; drive_en = 0; rsp_valid = 0; rsp_rdata = 0; cnt = 0.
//     Reset mid-transaction aborts the access. The bus is released on that same edge, with
//     no rsp_valid. The requester re-issues after reset.
//   States:
//     IDLE: req_ready = 1. On accept:
//       - latch addr_q, we_q, wdata_q;
//       - load cnt = (req_addr[15:8] == 8'hFF) ? DEV_WAIT-1 : RAM_WAIT-1;
//       - drive addr = req_addr and ctrl = req_we;
//       - set drive_en = req_we;
//       - go to ACCESS.
//     ACCESS: addr, ctrl and data are held stable. cnt decrements each cycle. When cnt == 0:
//       - load: capture data into rsp_rdata, then go to RESP;
//       - store: drop ctrl to 0 and drive_en to 0, then go to TURN.
//     TURN: one bus-idle cycle (no driver) so a following access never overlaps a store.
//       Then go to RESP.
//     RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE. addr keeps its last value
//       and ctrl = 0.
//   Latency:
//     - load: accept -> rsp_valid = WAIT + 1 cycles;
//     - store: WAIT + 2 cycles.
//     Back-to-back requests: the next accept happens in the cycle after RESP.
//   Boundaries:
//     - req_valid falling while busy is ignored; the access still completes.
//     - Request fields changing mid-access are ignored (latched copies are used).
//     - Decode boundary: 0xFEFF is RAM and 0xFF00 is peripheral.
//     - cnt width = $clog2(DEV_WAIT) (minimum 1); it never wraps because it is reloaded on
//       every accept.
//     - data is never driven with ctrl = 0, and never driven in IDLE/TURN/RESP.
// STRUCTURE
//   Shared package/include (para.v): ADDRBUS, DATABUS, PERIPH_PAGE = 8'hFF, state encodings.
//   Single module with no sub-modules. Tri-state is one continuous assign:
//   data = drive_en ? wdata_q : {DW{1'bz}}.
// TESTING
//   1. Load RAM 0x0010 (bus model returns 0x1234), RAM_WAIT = 2.
//      -> ctrl = 0, no drive; rsp_valid 3 cycles after accept; rsp_rdata = 0x1234.
//   2. Store 0x00A5 to LED 0xFF00.
//      -> ctrl = 1 and data = 0x00A5 held exactly DEV_WAIT cycles; TURN with data = 'z;
//         rsp_valid at DEV_WAIT + 2.
//   3. Store 0xFEFF then load 0xFF10.
//      -> RAM timing for the first, DEV_WAIT for the second; no cycle with both bus and
//         model driving data.
//   4. stall check: req_valid held across a load.
//      -> stall = 1 every cycle except the rsp_valid cycle; req_ready = 0 outside IDLE.
//   5. rst_n low in the middle of a peripheral store.
//      -> next edge: drive_en = 0, ctrl = 0, addr = 0, state IDLE, no rsp_valid.
//   6. Change req_addr and req_wdata mid-access.
//      -> bus signals unchanged until completion.

Source files
------------

// File: rtl/bus_master_lsu_pkg.sv
// Shared definitions for the load/store bus master.
//   ADDRBUS / DATABUS : default address and data bus widths
//   PERIPH_PAGE       : upper address byte that selects the slow peripheral page
//   state_e           : controller state encoding
//   is_periph()       : address-page decode helper
package bus_master_lsu_pkg;

    localparam int         ADDRBUS     = 16;
    localparam int         DATABUS     = 16;
    localparam logic [7:0] PERIPH_PAGE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // True when the upper address byte selects the peripheral page.
    function automatic logic is_periph(input logic [7:0] page);
        return (page == PERIPH_PAGE);
    endfunction

endpackage

// File: rtl/bus_master_lsu.sv
// Load/store bus master between the CPU MEM stage and the system bus.
// Accepts one request at a time, holds addr/ctrl/data for RAM_WAIT cycles
// (main memory) or DEV_WAIT cycles (peripheral page 0xFFxx), inserts a
// bus-idle turnaround cycle after stores, and returns a one-cycle rsp_valid.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/ready/we    : MEM-stage request handshake and direction
//   req_addr/req_wdata    : request address and store data
//   rsp_valid/rsp_rdata   : completion pulse and held load data
//   stall                 : freezes the upstream pipeline while busy
//   addr/data/ctrl        : system bus (data is tri-stated when not storing)
module bus_master_lsu
    import bus_master_lsu_pkg::*;
#(
    parameter int AW       = ADDRBUS,
    parameter int DW       = DATABUS,
    parameter int RAM_WAIT = 2,
    parameter int DEV_WAIT = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          stall,
    output logic [AW-1:0] addr,
    inout  wire  [DW-1:0] data,
    output logic          ctrl
);

    localparam int CW = (DEV_WAIT > 1) ? $clog2(DEV_WAIT) : 1;

    // Counter reload values: the access phase lasts (reload + 1) cycles.
    localparam logic [CW-1:0] RAM_LOAD = CW'(RAM_WAIT - 1);
    localparam logic [CW-1:0] DEV_LOAD = CW'(DEV_WAIT - 1);

    state_e        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic          ctrl_q,      ctrl_d;
    logic          drive_en_q,  drive_en_d;
    logic          we_q,        we_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        ctrl_d      = ctrl_q;
        drive_en_d  = drive_en_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    we_d       = req_we;
                    wdata_d    = req_wdata;
                    cnt_d      = is_periph(req_addr[AW-1 -: 8]) ? DEV_LOAD : RAM_LOAD;
                    ctrl_d     = req_we;
                    drive_en_d = req_we;
                    state_d    = ST_ACCESS;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == {CW{1'b0}}) begin
                    if (we_q) begin
                        // Release the bus; the turnaround cycle keeps it idle.
                        ctrl_d      = 1'b0;
                        drive_en_d  = 1'b0;
                        state_d     = ST_TURN;
                    end else begin
                        rsp_rdata_d = data;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_TURN: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                ctrl_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                ctrl_d     = 1'b0;
                drive_en_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and bus registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            addr_q      <= {AW{1'b0}};
            ctrl_q      <= 1'b0;
            drive_en_q  <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= {DW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ctrl_q      <= ctrl_d;
            drive_en_q  <= drive_en_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign data      = drive_en_q ? wdata_q : {DW{1'bz}};
    assign addr      = addr_q;
    assign ctrl      = ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign req_ready = (state_q == ST_IDLE);
    assign stall     = req_valid & ~rsp_valid_q;

endmodule

// File: tb/tb_bus_master_lsu.sv
// Self-checking bench for bus_master_lsu: directed scenarios followed by
// randomized loads/stores, each checked cycle by cycle against a
// transaction-level expectation (latency, bus hold, direction, data).
module tb_bus_master_lsu;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int RAM_WAIT = 2;
    localparam int DEV_WAIT = 200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          stall;
    logic [AW-1:0] addr;
    wire  [DW-1:0] data;
    logic          ctrl;

    // Bus model: a read-side device that drives data whenever the bus is in read direction.
    logic [DW-1:0] mdl_data;
    assign data = ctrl ? {DW{1'bz}} : mdl_data;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] last_rdata;

    bus_master_lsu #(
        .AW(AW), .DW(DW), .RAM_WAIT(RAM_WAIT), .DEV_WAIT(DEV_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .stall(stall),
        .addr(addr), .data(data), .ctrl(ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request; called at a negedge while the DUT is idle.
    task automatic do_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rv, input bit scramble);
        int  wait_c;
        int  exp_lat;
        logic exp_rsp;
        wait_c  = (a[15:8] == 8'hFF) ? DEV_WAIT : RAM_WAIT;
        exp_lat = wait_c + (we ? 2 : 1);
        mdl_data  = rv;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        for (int cyc = 1; cyc <= exp_lat; cyc++) begin
            @(negedge clk);
            exp_rsp = (cyc == exp_lat);
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp});
            chk("stall",     {31'd0, stall},     {31'd0, ~exp_rsp});
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
            chk("addr_hold", {16'd0, addr}, {16'd0, a});
            chk("ctrl", {31'd0, ctrl}, {31'd0, (we && cyc <= wait_c)});
            if (ctrl === 1'b1)
                chk("data_store", {16'd0, data}, {16'd0, wd});
            else
                chk("data_nodrive", {16'd0, data}, {16'd0, mdl_data});
            if (exp_rsp) begin
                if (!we) last_rdata = rv;
                chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, last_rdata});
            end
            if (scramble && cyc == 1) begin
                req_addr  = ~a;
                req_wdata = ~wd;
                req_we    = ~we;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("ctrl_after", {31'd0, ctrl}, 32'd0);
    endtask

    initial begin
        logic [7:0]    page;
        logic [AW-1:0] ra;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        mdl_data   = 16'h0000;
        last_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_addr",  {16'd0, addr}, 32'd0);
        chk("rst_ctrl",  {31'd0, ctrl}, 32'd0);
        chk("rst_rspv",  {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: RAM load, peripheral store, decode boundary pair.
        do_txn(1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0);
        do_txn(1'b1, 16'hFF00, 16'h00A5, 16'h0000, 1'b0);
        do_txn(1'b1, 16'hFEFF, 16'h5A3C, 16'h0000, 1'b0);
        do_txn(1'b0, 16'hFF10, 16'h0000, 16'hBEEF, 1'b0);
        // Request fields changing mid-access.
        do_txn(1'b0, 16'h0222, 16'h0000, 16'h7E01, 1'b1);
        do_txn(1'b1, 16'h0333, 16'hC001, 16'h0000, 1'b1);

        // Reset in the middle of a peripheral store.
        mdl_data  = 16'h0F0F;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'hFF20;
        req_wdata = 16'hA0A0;
        repeat (5) @(negedge clk);
        chk("mid_ctrl", {31'd0, ctrl}, 32'd1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_ctrl",  {31'd0, ctrl}, 32'd0);
        chk("abort_addr",  {16'd0, addr}, 32'd0);
        chk("abort_data",  {16'd0, data}, {16'd0, mdl_data});
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_rspv",  {31'd0, rsp_valid}, 32'd0);
        last_rdata = 16'h0000;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rspv", {31'd0, rsp_valid}, 32'd0);
        end

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            page = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            ra   = {page, 8'($urandom_range(0, 255))};
            do_txn(1'($urandom_range(0, 1)), ra, 16'($urandom_range(1, 65535)),
                   16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
